// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment BCD display driver.
// Segment patterns are active-low, written g..a (bit 6 = g, bit 0 = a).
package seg7_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0011000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   // Decimal digits needed for 2**width-1: floor(width*log10(2)) + 1.
   function automatic int bcd_digits(input int width);
      return (width * 30103) / 100000 + 1;
   endfunction

endpackage

// File: rtl/seg7_encode.sv
// BCD digit to active-low 7-segment pattern; non-decimal codes go dark.
module seg7_encode
   import seg7_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Binary-to-BCD (double dabble, one bit per cycle) feeding a time-multiplexed
// 7-segment display with leading-zero blanking and overflow dashes.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DIGITS   = 3,
   parameter int SCAN_DIV = 50000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [WIDTH-1:0]  value,
   input  logic              blank_lz,
   output logic              busy,
   output logic              valid,
   output logic              ovf,
   output logic [6:0]        seg,
   output logic [DIGITS-1:0] an
);

   localparam int BCD_N = bcd_digits(WIDTH);
   localparam int NIB   = (BCD_N > DIGITS) ? BCD_N : DIGITS;
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int SCN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   state_t                   state, state_nxt;
   logic [WIDTH-1:0]         bin_q;
   logic [NIB*4-1:0]         bcd_q, bcd_adj;
   logic [CNT_W-1:0]         cnt_q;
   logic                     blank_q;
   logic                     hi_nz;

   logic [DIGITS-1:0][3:0]   disp_dig;
   logic [DIGITS-1:0][6:0]   dig_seg;
   logic [DIGITS-1:0]        lz;
   logic                     disp_blank, disp_ovf, valid_q;
   logic [SCN_W-1:0]         scan_cnt;
   logic [IDX_W-1:0]         idx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (load) state_nxt = ST_SHIFT;
         ST_SHIFT: if (cnt_q == CNT_W'(1)) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < NIB; i++)
         if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         blank_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (load) begin
               bin_q   <= value;
               blank_q <= blank_lz;
               bcd_q   <= '0;
               cnt_q   <= CNT_W'(WIDTH);
            end
            ST_SHIFT: begin
               bcd_q <= {bcd_adj[NIB*4-2:0], bin_q[WIDTH-1]};
               bin_q <= bin_q << 1;
               cnt_q <= cnt_q - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Nibbles beyond the displayed digits only exist when the value can outgrow them.
   generate
      if (NIB > DIGITS) begin : g_hi
         assign hi_nz = |bcd_q[NIB*4-1:DIGITS*4];
      end else begin : g_no_hi
         assign hi_nz = 1'b0;
      end
   endgenerate

   // Commit happens only on the DONE edge, so an aborted conversion never leaks out.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         disp_dig   <= '0;
         disp_blank <= 1'b0;
         disp_ovf   <= 1'b0;
         valid_q    <= 1'b0;
      end else if (state == ST_DONE) begin
         disp_dig   <= bcd_q[DIGITS*4-1:0];
         disp_blank <= blank_q;
         disp_ovf   <= hi_nz;
         valid_q    <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scan_cnt <= '0;
         idx      <= '0;
      end else if (scan_cnt == SCN_W'(SCAN_DIV - 1)) begin
         scan_cnt <= '0;
         idx      <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end else begin
         scan_cnt <= scan_cnt + SCN_W'(1);
      end
   end

   generate
      for (genvar g = 0; g < DIGITS; g++) begin : g_enc
         seg7_encode u_enc (.digit(disp_dig[g]), .seg(dig_seg[g]));
      end
   endgenerate

   // lz[i]: digit i and every digit above it are zero.
   always_comb begin
      lz = '0;
      lz[DIGITS-1] = (disp_dig[DIGITS-1] == 4'd0);
      for (int i = DIGITS - 2; i >= 0; i--)
         lz[i] = (disp_dig[i] == 4'd0) && lz[i+1];
   end

   always_comb begin
      busy  = (state != ST_IDLE);
      valid = valid_q;
      ovf   = disp_ovf;
      an    = '1;
      seg   = SEG_BLANK;
      if (valid_q) begin
         an[idx] = 1'b0;
         if (disp_ovf)                              seg = SEG_DASH;
         else if (disp_blank && idx != '0 && lz[idx]) seg = SEG_BLANK;
         else                                       seg = dig_seg[idx];
      end
   end

endmodule
